// File: rtl/fp_mult_exp_pipe_if.sv
// Operand/result handshake bundle for fp_mult_exp_pipe.
// Both sides use valid/ready: a beat moves on a rising clk edge where valid and ready are both 1.
`ifndef FP16
`define FP16 16
`endif
`ifndef FP32
`define FP32 32
`endif
`ifndef FP64
`define FP64 64
`endif
`ifndef GET_EXP_LEN
`define GET_EXP_LEN(f) (((f) == 16) ? 5 : (((f) == 64) ? 11 : 8))
`endif

interface fp_mult_exp_pipe_if #(
   parameter int exp_len = 8
);
   logic               in_valid;
   logic               in_ready;
   logic [exp_len-1:0] a_exp;
   logic [exp_len-1:0] b_exp;
   logic               a_man_nz;
   logic               b_man_nz;
   logic               out_valid;
   logic               out_ready;
   logic [exp_len+1:0] sum_exp;
   logic [1:0]         res_class;
   logic               ovf;
   logic               unf;

   modport master (
      output in_valid, a_exp, b_exp, a_man_nz, b_man_nz, out_ready,
      input  in_ready, out_valid, sum_exp, res_class, ovf, unf
   );

   modport slave (
      input  in_valid, a_exp, b_exp, a_man_nz, b_man_nz, out_ready,
      output in_ready, out_valid, sum_exp, res_class, ovf, unf
   );
endinterface

// File: rtl/fp_mult_exp_pipe.sv
// Exponent path of an FP multiplier: biased exponent sum, special-value class and
// overflow/underflow flags, computed in stage 1 and carried through an elastic pipeline.
`ifndef FP32
`define FP32 32
`endif
`ifndef GET_EXP_LEN
`define GET_EXP_LEN(f) (((f) == 16) ? 5 : (((f) == 64) ? 11 : 8))
`endif

module fp_mult_exp_pipe #(
   parameter int data_format = `FP32,
   parameter int PIPE_STAGES = 2          // legal range 1..4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   fp_mult_exp_pipe_if.slave    bus
);
   localparam int exp_len = `GET_EXP_LEN(data_format);
   localparam int bias    = 2 ** (exp_len - 1) - 1;
   localparam int last    = PIPE_STAGES - 1;

   localparam logic [exp_len+1:0] bias_w = bias[exp_len+1:0];
   localparam logic [exp_len+1:0] max_w  = {2'b00, {exp_len{1'b1}}};

   localparam logic [1:0] cls_norm = 2'b00;
   localparam logic [1:0] cls_zero = 2'b01;
   localparam logic [1:0] cls_inf  = 2'b10;
   localparam logic [1:0] cls_nan  = 2'b11;

   typedef struct packed {
      logic [exp_len+1:0] sum;
      logic [1:0]         cls;
      logic               ovf;
      logic               unf;
   } stage_t;

   logic [PIPE_STAGES-1:0] vld;
   logic [PIPE_STAGES-1:0] ld;
   stage_t                 dat [PIPE_STAGES];
   stage_t                 s0;

   logic a_nan, a_inf, a_zero;
   logic b_nan, b_inf, b_zero;

   // Stage-1 arithmetic and classification.
   always_comb begin
      a_nan  = (&bus.a_exp) &&  bus.a_man_nz;
      a_inf  = (&bus.a_exp) && !bus.a_man_nz;
      a_zero = (bus.a_exp == '0);
      b_nan  = (&bus.b_exp) &&  bus.b_man_nz;
      b_inf  = (&bus.b_exp) && !bus.b_man_nz;
      b_zero = (bus.b_exp == '0);

      s0.sum = {2'b00, bus.a_exp} + {2'b00, bus.b_exp} - bias_w;

      if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero))
         s0.cls = cls_nan;
      else if (a_inf || b_inf)
         s0.cls = cls_inf;
      else if (a_zero || b_zero)
         s0.cls = cls_zero;
      else
         s0.cls = cls_norm;

      // Flags only carry meaning for normal results; signed compare on the wide sum.
      s0.ovf = (s0.cls == cls_norm) && ($signed(s0.sum) >= $signed(max_w));
      s0.unf = (s0.cls == cls_norm) && (s0.sum[exp_len+1] || (s0.sum == '0));
   end

   // Load enables ripple backward from out_ready so a full pipe can move every cycle.
   always_comb begin
      logic go;
      go = bus.out_ready;
      ld = '0;
      for (int i = PIPE_STAGES - 1; i >= 0; i--) begin
         ld[i] = !vld[i] || go;
         go    = ld[i];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld <= '0;
         for (int i = 0; i < PIPE_STAGES; i++)
            dat[i] <= '0;
      end else begin
         if (ld[0]) begin
            vld[0] <= bus.in_valid;
            if (bus.in_valid)
               dat[0] <= s0;
         end
         for (int i = 1; i < PIPE_STAGES; i++) begin
            if (ld[i]) begin
               vld[i] <= vld[i-1];
               if (vld[i-1])
                  dat[i] <= dat[i-1];
            end
         end
      end
   end

   assign bus.in_ready  = ld[0];
   assign bus.out_valid = vld[last];
   assign bus.sum_exp   = dat[last].sum;
   assign bus.res_class = dat[last].cls;
   assign bus.ovf       = dat[last].ovf;
   assign bus.unf       = dat[last].unf;
endmodule

// File: tb/tb_fp_mult_exp_pipe.sv
// Directed bench for fp_mult_exp_pipe (FP32, 2 stages): vector table, stalled stream,
// and a full-pipe asynchronous reset sequence.
module tb_fp_mult_exp_pipe;
   localparam int W = 14;

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic       anz;
      logic       bnz;
      logic [9:0] sum;
      logic [1:0] cls;
      logic       ovf;
      logic       unf;
   } vec_t;

   logic clk;
   logic rst_n;
   int   pass_cnt;
   int   total_cnt;
   vec_t vecs [17];
   logic [W-1:0] exp_q [$];

   fp_mult_exp_pipe_if #(.exp_len(8)) bus ();

   fp_mult_exp_pipe #(.data_format(`FP32), .PIPE_STAGES(2)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      total_cnt++;
      if (act === req)
         pass_cnt++;
      else
         $display("FAIL %s: got %0h, expected %0h", name, act, req);
   endtask

   task automatic drive_vec(input int i);
      bus.a_exp    = vecs[i].a;
      bus.b_exp    = vecs[i].b;
      bus.a_man_nz = vecs[i].anz;
      bus.b_man_nz = vecs[i].bnz;
   endtask

   function automatic logic [W-1:0] pack_exp(input int i);
      return {vecs[i].sum, vecs[i].cls, vecs[i].ovf, vecs[i].unf};
   endfunction

   function automatic logic [W-1:0] pack_out();
      return {bus.sum_exp, bus.res_class, bus.ovf, bus.unf};
   endfunction

   // Called at posedge+1 with an empty pipe; returns at posedge+1 with it empty again.
   task automatic send_and_check(input int i);
      drive_vec(i);
      bus.in_valid  = 1'b1;
      bus.out_ready = 1'b1;
      @(negedge clk);
      chk($sformatf("v%0d_in_ready", i), 32'(bus.in_ready), 32'd1);
      @(posedge clk);
      #1 bus.in_valid = 1'b0;
      @(negedge clk);
      chk($sformatf("v%0d_lat1_valid", i), 32'(bus.out_valid), 32'd0);
      @(negedge clk);
      chk($sformatf("v%0d_lat2_valid", i), 32'(bus.out_valid), 32'd1);
      chk($sformatf("v%0d_sum", i), 32'(bus.sum_exp), 32'(vecs[i].sum));
      chk($sformatf("v%0d_cls", i), 32'(bus.res_class), 32'(vecs[i].cls));
      chk($sformatf("v%0d_ovf", i), 32'(bus.ovf), 32'(vecs[i].ovf));
      chk($sformatf("v%0d_unf", i), 32'(bus.unf), 32'(vecs[i].unf));
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [W-1:0] held;
      logic [W-1:0] exp_v;
      logic         prev_stall;
      logic         pat [4];
      int           idx, got, occ, cyc;
      logic         in_fire, out_fire;

      pass_cnt  = 0;
      total_cnt = 0;
      //           a       b     anz   bnz   sum       cls    ovf   unf
      vecs[0]  = '{8'd127, 8'd127, 1'b1, 1'b1, 10'd127,  2'b00, 1'b0, 1'b0};
      vecs[1]  = '{8'd200, 8'd200, 1'b0, 1'b1, 10'h111,  2'b00, 1'b1, 1'b0};
      vecs[2]  = '{8'd10,  8'd10,  1'b1, 1'b0, 10'h395,  2'b00, 1'b0, 1'b1};
      vecs[3]  = '{8'd255, 8'd100, 1'b1, 1'b0, 10'd228,  2'b11, 1'b0, 1'b0};
      vecs[4]  = '{8'd255, 8'd0,   1'b0, 1'b0, 10'd128,  2'b11, 1'b0, 1'b0};
      vecs[5]  = '{8'd255, 8'd100, 1'b0, 1'b1, 10'd228,  2'b10, 1'b0, 1'b0};
      vecs[6]  = '{8'd0,   8'd100, 1'b0, 1'b1, 10'h3e5,  2'b01, 1'b0, 1'b0};
      vecs[7]  = '{8'd191, 8'd191, 1'b1, 1'b1, 10'd255,  2'b00, 1'b1, 1'b0};
      vecs[8]  = '{8'd190, 8'd191, 1'b1, 1'b1, 10'd254,  2'b00, 1'b0, 1'b0};
      vecs[9]  = '{8'd64,  8'd63,  1'b1, 1'b1, 10'd0,    2'b00, 1'b0, 1'b1};
      vecs[10] = '{8'd64,  8'd64,  1'b0, 1'b0, 10'd1,    2'b00, 1'b0, 1'b0};
      vecs[11] = '{8'd254, 8'd254, 1'b1, 1'b1, 10'h17d,  2'b00, 1'b1, 1'b0};
      vecs[12] = '{8'd255, 8'd255, 1'b0, 1'b1, 10'h17f,  2'b11, 1'b0, 1'b0};
      vecs[13] = '{8'd255, 8'd255, 1'b0, 1'b0, 10'h17f,  2'b10, 1'b0, 1'b0};
      vecs[14] = '{8'd0,   8'd0,   1'b0, 1'b0, 10'h381,  2'b01, 1'b0, 1'b0};
      vecs[15] = '{8'd1,   8'd1,   1'b1, 1'b1, 10'h383,  2'b00, 1'b0, 1'b1};
      vecs[16] = '{8'd0,   8'd5,   1'b1, 1'b1, 10'h386,  2'b01, 1'b0, 1'b0};

      rst_n         = 1'b0;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      drive_vec(0);

      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
      chk("rst_in_ready",  32'(bus.in_ready),  32'd1);
      chk("rst_sum",       32'(bus.sum_exp),   32'd0);
      chk("rst_cls",       32'(bus.res_class), 32'd0);
      chk("rst_flags",     32'({bus.ovf, bus.unf}), 32'd0);
      @(posedge clk);
      #1 rst_n = 1'b1;

      // Table-driven single transactions.
      for (int i = 0; i < 17; i++)
         send_and_check(i);

      // Stream of 8 with out_ready pattern 1,0,0,1 repeating.
      pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1;
      idx = 0; got = 0; occ = 0; cyc = 0;
      prev_stall = 1'b0;
      held = '0;
      while (got < 8 && cyc < 200) begin
         bus.in_valid  = (idx < 8);
         if (idx < 8) drive_vec(idx);
         bus.out_ready = pat[cyc % 4];
         @(negedge clk);
         in_fire  = bus.in_valid && bus.in_ready;
         out_fire = bus.out_valid && bus.out_ready;
         chk($sformatf("stream_in_ready_c%0d", cyc), 32'(bus.in_ready),
             32'(!(occ == 2 && !bus.out_ready)));
         if (prev_stall)
            chk($sformatf("stream_hold_c%0d", cyc), 32'(pack_out()), 32'(held));
         if (out_fire) begin
            if (exp_q.size() == 0) begin
               chk($sformatf("stream_extra_c%0d", cyc), 32'd1, 32'd0);
            end else begin
               exp_v = exp_q.pop_front();
               chk($sformatf("stream_res%0d", got), 32'(pack_out()), 32'(exp_v));
            end
            got++;
         end
         prev_stall = bus.out_valid && !bus.out_ready;
         held       = pack_out();
         if (in_fire) begin
            exp_q.push_back(pack_exp(idx));
            idx++;
         end
         occ = occ + (in_fire ? 1 : 0) - (out_fire ? 1 : 0);
         @(posedge clk);
         #1;
         cyc++;
      end
      bus.in_valid = 1'b0;
      chk("stream_count", 32'(got), 32'd8);
      chk("stream_queue_empty", 32'(exp_q.size()), 32'd0);

      // Drain anything left, then fill the pipe with out_ready low.
      bus.out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1 bus.out_ready = 1'b0;
      drive_vec(0);
      bus.in_valid = 1'b1;
      @(posedge clk);
      #1 drive_vec(1);
      @(posedge clk);
      #1 bus.in_valid = 1'b0;
      @(negedge clk);
      chk("full_in_ready", 32'(bus.in_ready), 32'd0);
      chk("full_out_valid", 32'(bus.out_valid), 32'd1);
      chk("full_head_sum", 32'(bus.sum_exp), 32'(vecs[0].sum));

      // One-cycle reset pulse; outputs must clear before any clock edge.
      @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      chk("async_rst_out_valid", 32'(bus.out_valid), 32'd0);
      chk("async_rst_in_ready",  32'(bus.in_ready),  32'd1);
      chk("async_rst_sum",       32'(bus.sum_exp),   32'd0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      bus.out_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         chk($sformatf("post_rst_no_stale_%0d", k), 32'(bus.out_valid), 32'd0);
      end
      @(posedge clk);
      #1;
      send_and_check(2);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

   // Global watchdog so the run always ends.
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1);
   end
endmodule

// File: doc/fp_mult_exp_pipe.md
FP_MULT_EXP_PIPE -- requirements
Module: fp_mult_exp_pipe

Interface
REQ-001 The block SHALL have parameter data_format, default `FP32, selecting the operand format; exp_len = `GET_EXP_LEN(data_format), bias = 2^(exp_len-1)-1.
REQ-002 The block SHALL have parameter PIPE_STAGES, default 2, legal range 1..4, giving the number of register stages.
REQ-003 clk  input  1  sole clock, rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 in_valid  input  1  operand pair present.
REQ-006 in_ready  output  1  block accepts operands this cycle.
REQ-007 a_exp, b_exp  input  exp_len each  biased operand exponents.
REQ-008 a_man_nz, b_man_nz  input  1 each  operand mantissa field is non-zero.
REQ-009 out_valid  output  1  result present.
REQ-010 out_ready  input  1  downstream accepts result.
REQ-011 sum_exp  output  exp_len+2  signed two's-complement a_exp+b_exp-bias.
REQ-012 res_class  output  2  00 normal, 01 zero, 10 inf, 11 NaN.
REQ-013 ovf, unf  output  1 each  exponent overflow / underflow flags, valid only when res_class=00.

Function
REQ-014 sum_exp SHALL equal zero-extended a_exp plus zero-extended b_exp minus bias, computed exactly in exp_len+2 bits with no saturation.
REQ-015 Classification per operand SHALL be: exp all-ones with man_nz=1 -> NaN; exp all-ones with man_nz=0 -> inf; exp zero -> zero (subnormals flushed); otherwise normal.
REQ-016 res_class priority SHALL be: NaN if either operand is NaN or one operand is inf and the other is zero; else inf if either is inf; else zero if either is zero; else normal.
REQ-017 For res_class=00, ovf SHALL be 1 iff sum_exp >= 2^exp_len-1, and unf SHALL be 1 iff sum_exp <= 0; for other classes ovf=unf=0.
REQ-018 Arithmetic and classification SHALL be computed in the first stage; later stages only carry data.
REQ-019 Each stage SHALL hold a valid bit and SHALL load when it is empty or its contents advance to the next stage (or to the output when last) in the same cycle.
REQ-020 in_ready SHALL be combinationally 1 when stage 1 is empty or stage 1 advances this cycle; a transfer occurs iff in_valid and in_ready are both 1.
REQ-021 A result SHALL leave the block iff out_valid and out_ready are both 1; out_valid SHALL equal the last stage's valid bit.
REQ-022 With out_ready held 1, latency SHALL be exactly PIPE_STAGES cycles from input transfer to out_valid, at a throughput of one result per cycle.
REQ-023 While out_valid=1 and out_ready=0, sum_exp, res_class, ovf and unf SHALL hold stable and no result SHALL be lost or duplicated.
REQ-024 A full pipeline with out_ready=0 SHALL hold exactly PIPE_STAGES results and drive in_ready=0.
REQ-025 When the pipeline is full, a simultaneous output transfer and input transfer in the same cycle SHALL be accepted without a bubble.
REQ-026 Results SHALL emerge in input order.

Reset
REQ-027 When rst_n=0, all stage valid bits SHALL clear asynchronously, giving out_valid=0 and in_ready=1 (from the combinational rule in REQ-020).
REQ-028 Data registers SHALL reset to 0, so that sum_exp=0, res_class=00 and ovf=unf=0.
REQ-029 Reset asserted mid-operation SHALL discard all in-flight results; no out_valid pulse SHALL occur for them after rst_n rises.

Verification
REQ-030 FP32, PIPE_STAGES=2: a_exp=127, b_exp=127, normal mantissas -> after 2 cycles sum_exp=127, res_class=00, ovf=0, unf=0.
REQ-031 FP32: a_exp=200, b_exp=200 -> sum_exp=273, ovf=1; a_exp=10, b_exp=10 -> sum_exp=-107 (10'h395), unf=1.
REQ-032 FP32: a_exp=255 with a_man_nz=1 -> res_class=11; a_exp=255 with a_man_nz=0 and b_exp=0 -> res_class=11; a_exp=255 with a_man_nz=0 and b_exp=100 -> res_class=10.
REQ-033 Back-to-back stream of 8 operands while out_ready toggles 1,0,0,1,... -> all 8 results appear in order, unchanged while stalled; in_ready=0 only when 2 results are held.
REQ-034 Pipeline full, rst_n pulsed low for 1 cycle -> out_valid=0 immediately; no stale result appears afterward; first new input appears 2 cycles after acceptance.
